// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's memory port, redirect input and decode handshake.
// The master modport is the fetch stage; slave is the memory/decode side.
interface fetch_stage_if;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output mem_address, mem_read_write, inst_valid, inst, inst_pc, fault, fetch_count,
        input  mem_data_out, redirect_valid, redirect_target, inst_ready
    );

    modport slave (
        input  mem_address, mem_read_write, inst_valid, inst, inst_pc, fault, fetch_count,
        output mem_data_out, redirect_valid, redirect_target, inst_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads memory combinationally and registers
// one word for decode behind a valid/ready handshake, with redirect and sticky fault.
module fetch_stage #(
    parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
    parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        fault_q;
    logic [31:0] count_q;

    logic handshake;
    logic pc_legal;
    logic target_legal;

    assign handshake    = valid_q && bus.inst_ready;
    assign pc_legal     = (pc_q >= STARTING_ADDR) && (pc_q <= LAST_ADDR);
    assign target_legal = (bus.redirect_target[1:0] == 2'b00) &&
                          (bus.redirect_target >= STARTING_ADDR) &&
                          (bus.redirect_target <= LAST_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            pc_q      <= STARTING_ADDR;
            valid_q   <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            fault_q   <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            if (handshake) begin
                count_q <= count_q + 32'd1;
            end
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.redirect_valid) begin
                        valid_q <= 1'b0;
                        if (target_legal) begin
                            pc_q <= bus.redirect_target;
                        end else begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end else if (!pc_legal) begin
                        // The held word survives the fault; it only drops once consumed.
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        if (handshake) begin
                            valid_q <= 1'b0;
                        end
                    end else if (!valid_q || bus.inst_ready) begin
                        inst_q    <= bus.mem_data_out;
                        inst_pc_q <= pc_q;
                        valid_q   <= 1'b1;
                        pc_q      <= pc_q + 32'd4;
                    end
                end
                ST_FAULT: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_FAULT;
                    fault_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_address    = pc_q;
    assign bus.mem_read_write = 1'b0;
    assign bus.inst_valid     = valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.fault          = fault_q;
    assign bus.fetch_count    = count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then random
// ready/redirect/reset traffic, all checked every cycle against a behavioural model.
module tb_fetch_stage;
    localparam logic [31:0] START = 32'h0100_0000;
    localparam logic [31:0] DEPTH = 32'h0010_0000;
    localparam logic [31:0] LAST  = START + DEPTH - 32'd4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    fetch_stage_if bus();

    fetch_stage #(
        .STARTING_ADDR   (START),
        .MEM_DEPTH_BYTES (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == START) return 32'h0000_0013;
        if (a == START + 32'd4) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign bus.mem_data_out = mem_word(bus.mem_address);

    // Behavioural model: phase 0 = booting, 1 = running, 2 = faulted.
    int          m_phase;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    logic        m_fault;
    logic [31:0] m_count;

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= START) && (a <= LAST);
    endfunction

    task automatic model_step();
        bit took;
        if (reset) begin
            m_phase = 0; m_pc = START; m_valid = 0; m_inst = 0; m_inst_pc = 0;
            m_fault = 0; m_count = 0;
            return;
        end
        took = m_valid && bus.inst_ready;
        if (took) m_count = m_count + 32'd1;
        if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 2) begin
            if (took) m_valid = 0;
        end else if (bus.redirect_valid) begin
            m_valid = 0;
            if (legal(bus.redirect_target)) m_pc = bus.redirect_target;
            else begin m_phase = 2; m_fault = 1; end
        end else if (!legal(m_pc)) begin
            m_phase = 2; m_fault = 1;
            if (took) m_valid = 0;
        end else if (!m_valid || bus.inst_ready) begin
            m_inst = mem_word(m_pc); m_inst_pc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_address", bus.mem_address, m_pc);
            check("mem_read_write", {31'd0, bus.mem_read_write}, 32'd0);
            check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_valid});
            check("inst", bus.inst, m_inst);
            check("inst_pc", bus.inst_pc, m_inst_pc);
            check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
            check("fetch_count", bus.fetch_count, m_count);
        end
    end

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.inst_ready      = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        @(negedge clock);
        do_reset();
        chk_en = 1'b1;

        // Reset values and first two words with ready held high.
        check("pin_reset_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("pin_reset_pc", bus.mem_address, 32'h0100_0000);
        tick();
        check("pin_boot_no_capture", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        check("pin_w0_inst", bus.inst, 32'h0000_0013);
        check("pin_w0_pc", bus.inst_pc, 32'h0100_0000);
        tick();
        check("pin_w1_inst", bus.inst, 32'h0050_0093);
        check("pin_w1_pc", bus.inst_pc, 32'h0100_0004);
        tick();
        check("pin_count2", bus.fetch_count, 32'd2);

        // Back-pressure for three cycles after the first word, then resume.
        do_reset();
        tick();
        bus.inst_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pin_stall_inst", bus.inst, 32'h0000_0013);
            check("pin_stall_addr", bus.mem_address, 32'h0100_0004);
            check("pin_stall_count", bus.fetch_count, 32'd0);
        end
        bus.inst_ready = 1'b1;
        tick();
        check("pin_resume_pc", bus.inst_pc, 32'h0100_0004);
        check("pin_resume_count", bus.fetch_count, 32'd1);

        // Redirect while a word is held.
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0100_0040;
        tick();
        bus.redirect_valid = 1'b0;
        check("pin_redir_flush", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        check("pin_redir_pc", bus.inst_pc, 32'h0100_0040);
        check("pin_redir_valid", {31'd0, bus.inst_valid}, 32'd1);

        // Misaligned redirect faults; later redirects are ignored.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0100_0042;
        tick();
        check("pin_misalign_fault", {31'd0, bus.fault}, 32'd1);
        check("pin_misalign_flush", {31'd0, bus.inst_valid}, 32'd0);
        bus.redirect_target = 32'h0100_0000;
        tick();
        tick();
        bus.redirect_valid = 1'b0;
        check("pin_fault_ignore", bus.mem_address, 32'h0100_0044);
        check("pin_fault_sticky", {31'd0, bus.fault}, 32'd1);

        // Last legal word is delivered, then the stage faults without capturing.
        bus.inst_ready = 1'b1;
        do_reset();
        check("pin_fault_cleared", {31'd0, bus.fault}, 32'd0);
        tick();
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h010F_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("pin_last_pc", bus.inst_pc, 32'h010F_FFFC);
        tick();
        check("pin_last_fault", {31'd0, bus.fault}, 32'd1);
        check("pin_last_nocap", bus.inst_pc, 32'h010F_FFFC);
        check("pin_last_addr", bus.mem_address, 32'h0110_0000);

        // Reset mid-stream with a word held.
        do_reset();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("pin_midrst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("pin_midrst_inst", bus.inst, 32'd0);
        check("pin_midrst_count", bus.fetch_count, 32'd0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            int sel;
            bus.inst_ready     = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 11) == 0);
            sel = $urandom_range(0, 15);
            if (sel == 0)      bus.redirect_target = START + 32'd2;
            else if (sel == 1) bus.redirect_target = START - 32'd4;
            else if (sel == 2) bus.redirect_target = START + DEPTH;
            else if (sel <= 4) bus.redirect_target = LAST - 32'd4 * $urandom_range(0, 3);
            else               bus.redirect_target = START + 32'd4 * $urandom_range(0, 255);
            reset = ($urandom_range(0, 79) == 0);
            tick();
        end
        reset = 1'b0;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of main memory. It owns the program counter, drives the memory's address and read/write lines, and captures the returned 32-bit word into an output register. It hands that word to decode through a valid/ready handshake. It also supports branch redirect, back-pressure, and a sticky fault for misaligned or out-of-range PCs.

## Interface
- STARTING_ADDR, 'h01000000, byte address of the first memory location and the reset PC
- MEM_DEPTH_BYTES, 'h0100000, memory size in bytes; the legal PC range is [STARTING_ADDR, STARTING_ADDR+MEM_DEPTH_BYTES-4]
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- mem_address  out  32  equals `pc` combinationally
- mem_read_write  out  1  constant 0 (READ); this stage never writes
- mem_data_out  in  32  word returned by memory for `mem_address`, valid in the same cycle
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_target  in  32  new PC when `redirect_valid`=1
- inst_valid  out  1  `inst`/`inst_pc` hold a fetched word
- inst_ready  in  1  decode accepts the word when `inst_valid && inst_ready`
- inst  out  32  fetched instruction word
- inst_pc  out  32  byte address `inst` was fetched from
- fault  out  1  sticky; an illegal PC was reached
- fetch_count  out  32  number of completed handshakes since reset, wraps modulo 2^32

## Operation
- Internal `pc` register (32b) and state machine with states BOOT, RUN, FAULT.
- Reset (sampled high at a posedge):
  - state=BOOT, pc=STARTING_ADDR.
  - inst_valid=0, inst=0, inst_pc=0, fault=0, fetch_count=0.
- BOOT: no capture; goes to RUN at the next edge. Redirect is ignored in BOOT.
- RUN, each edge, in priority order:
  1. redirect_valid=1: flush (inst_valid<=0). If redirect_target[1:0]!=0 or the target is outside the legal range: state<=FAULT, fault<=1, pc unchanged. Otherwise pc<=redirect_target.
  2. pc outside the legal range: state<=FAULT, fault<=1. The held word is kept, not flushed.
  3. capture allowed (!inst_valid || inst_ready): inst<=mem_data_out, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
  4. otherwise (stall): pc, inst, inst_pc and inst_valid hold.
- FAULT:
  - No new captures; redirect is ignored.
  - A held word stays valid until its handshake completes, then inst_valid<=0.
  - Only reset leaves FAULT.
- fetch_count increments on every edge where inst_valid && inst_ready, in any state, including the edge on which a redirect flushes.
- pc+4 is 32-bit unsigned. After the last legal word, pc becomes out of range and rule 2 fires on the following edge.

## Timing
- mem_address follows pc with zero latency. Memory data is consumed in the same cycle.
- Reset to first word:
  - First edge with reset=0: BOOT->RUN.
  - Second edge: inst_valid=1, inst_pc=STARTING_ADDR.
- Steady state, inst_ready=1: one word per cycle, inst_pc advancing by 4.
- Redirect:
  - Asserted in cycle N: inst_valid=0 in cycle N+1.
  - Word at the target has inst_valid=1 in cycle N+2.
  - A handshake in cycle N still counts; the next word is not captured.
- Back-pressure: with inst_valid=1 and inst_ready=0, every output is stable and pc does not advance. When ready rises, the handshake and the next capture happen on the same edge.
- Reset mid-stream or in FAULT: all state returns to its reset values on that edge, and any held word is discarded.

## Test plan
- Reset, then memory preloaded with words 0x00000013 at 0x01000000 and 0x00500093 at 0x01000004, inst_ready=1 -> inst_valid rises at the 2nd edge after reset with inst=0x00000013, inst_pc=0x01000000; next cycle inst=0x00500093, inst_pc=0x01000004; fetch_count=2 after two cycles.
- Hold inst_ready=0 for 3 cycles after the first word -> inst/inst_pc frozen and mem_address=0x01000004 held; fetch_count unchanged; on release the stream resumes with no word skipped or duplicated.
- redirect_valid with target 0x01000040 while a word is held -> inst_valid=0 the next cycle, then inst_pc=0x01000040 one cycle later.
- Redirect to 0x01000042 -> fault=1 and inst_valid=0 on the following cycle; further redirects to 0x01000000 are ignored; fault clears only after reset.
- Redirect to 0x010FFFFC (the last legal word) -> that word is delivered; on the next edge fault=1 with no capture from 0x01100000.
- Assert reset while in RUN with inst_valid=1 -> all outputs return to their reset values at that edge; restart follows the first scenario.
